// File: rtl/mc_control_fsm_pkg.sv
// ctrl_pkg: state encodings, opcodes, alu_control codes and alu_op codes shared by the multicycle control unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
`ifdef MC_CONTROL_JALR_EN
    S_BEQ      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_LINK = 4'd12
`else
    S_BEQ      = 4'd10
`endif
  } state_e;
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction fields and zero flag in, datapath controls and debug state out; master=datapath side, slave=control unit
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal_op;
  logic [3:0] state_o;
  modport master (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, illegal_op, state_o
  );
  modport slave (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, illegal_op, state_o
  );
endinterface

// File: rtl/mc_control_fsm_alu_dec.sv
// alu_dec: combinational ALU decoder; in alu_op, funct3, op5, funct7b5; out alu_control
module alu_dec
  import ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = alu_op == ALU_OP_SUB   ? ALU_SUB :
                  alu_op != ALU_OP_FUNCT ? ALU_ADD :
                  funct3 == 3'b000       ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010       ? ALU_SLT :
                  funct3 == 3'b110       ? ALU_OR :
                  funct3 == 3'b111       ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RISC-V control FSM; ports clk, rst_n (async active-low), bus (mc_control_fsm_if.slave); MC_CONTROL_JALR_EN enables jalr
module mc_control_fsm
  import ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mc_control_fsm_if.slave   bus
);
  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_control;
  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = ALU_OP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        state_d = (bus.op == OP_LOAD || bus.op == OP_STORE) ? S_MEMADR :
                  bus.op == OP_RTYPE ? S_EXECR :
                  bus.op == OP_ITYPE ? S_EXECI :
                  bus.op == OP_JAL   ? S_JAL :
                  bus.op == OP_BEQ   ? S_BEQ :
`ifdef MC_CONTROL_JALR_EN
                  bus.op == OP_JALR  ? S_JALR :
`endif
                  S_FETCH;
        illegal = state_d == S_FETCH;
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        src_a  = 2'b10;
        alu_op = ALU_OP_SUB;
        branch = 1'b1;
      end
`ifdef MC_CONTROL_JALR_EN
      S_JALR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end
  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (alu_control)
  );
  assign bus.pc_write    = rst_n & (pc_update | (branch & bus.zero));
  assign bus.ir_write    = rst_n & ir_write;
  assign bus.mem_write   = rst_n & mem_write;
  assign bus.reg_write   = rst_n & reg_write;
  assign bus.illegal_op  = rst_n & illegal;
  assign bus.adr_src     = adr_src;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.alu_control = alu_control;
  assign bus.state_o     = state_q;
  assign bus.imm_src     = bus.op == OP_STORE ? 2'b01 :
                           bus.op == OP_BEQ   ? 2'b10 :
                           bus.op == OP_JAL   ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed-vector bench for mc_control_fsm; vector = {pw,adr,mw,iw,rs,sa,sb,ac,imm,rw,ill,state}
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [20:0] e;
  logic [20:0] obs;
  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.imm_src,
                bus.reg_write, bus.illegal_op, bus.state_o};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL reset_hold got=%b exp=%b", obs, e); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    e = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL reset_release_fetch got=%b exp=%b", obs, e); else passed++;
  endtask
  task automatic test_lw();
    bus.op = 7'b0000011;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0,1'b0,4'd1};
    total++; if (obs !== e) $display("FAIL lw_decode got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,2'b00,1'b0,1'b0,4'd2};
    total++; if (obs !== e) $display("FAIL lw_memadr got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,1'b0,1'b0,4'd3};
    total++; if (obs !== e) $display("FAIL lw_memread got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,3'b000,2'b00,1'b1,1'b0,4'd4};
    total++; if (obs !== e) $display("FAIL lw_memwb got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL lw_back_to_fetch got=%b exp=%b", obs, e); else passed++;
  endtask
  task automatic test_rtype_sub();
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0,1'b0,4'd1};
    total++; if (obs !== e) $display("FAIL rsub_decode got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,2'b00,1'b0,1'b0,4'd6};
    total++; if (obs !== e) $display("FAIL rsub_execr got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,1'b1,1'b0,4'd8};
    total++; if (obs !== e) $display("FAIL rsub_aluwb got=%b exp=%b", obs, e); else passed++;
    tick();
    total++; if (obs[3:0] !== 4'd0) $display("FAIL rsub_4cycle got=%0d exp=0", obs[3:0]); else passed++;
  endtask
  task automatic test_itype();
    bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    tick(); tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,2'b00,1'b0,1'b0,4'd7};
    total++; if (obs !== e) $display("FAIL addi_f7b5_execi got=%b exp=%b", obs, e); else passed++;
    bus.funct3 = 3'b110; #1;
    total++; if (bus.alu_control !== 3'b011) $display("FAIL ori_alu got=%b exp=011", bus.alu_control); else passed++;
    bus.funct3 = 3'b111; #1;
    total++; if (bus.alu_control !== 3'b010) $display("FAIL andi_alu got=%b exp=010", bus.alu_control); else passed++;
    bus.funct3 = 3'b010; #1;
    total++; if (bus.alu_control !== 3'b100) $display("FAIL slti_alu got=%b exp=100", bus.alu_control); else passed++;
    bus.funct3 = 3'b001; #1;
    total++; if (bus.alu_control !== 3'b000) $display("FAIL other_funct3_alu got=%b exp=000", bus.alu_control); else passed++;
    tick(); tick();
    total++; if (obs[3:0] !== 4'd0) $display("FAIL itype_end got=%0d exp=0", obs[3:0]); else passed++;
  endtask
  task automatic test_beq();
    bus.op = 7'b1100011; bus.zero = 1'b1;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b10,1'b0,1'b0,4'd1};
    total++; if (obs !== e) $display("FAIL beq_decode got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,2'b10,1'b0,1'b0,4'd10};
    total++; if (obs !== e) $display("FAIL beq_taken got=%b exp=%b", obs, e); else passed++;
    bus.zero = 1'b0; #1;
    total++; if (bus.pc_write !== 1'b0) $display("FAIL beq_zero_toggle got=%b exp=0", bus.pc_write); else passed++;
    tick();
    total++; if (obs[3:0] !== 4'd0) $display("FAIL beq_3cycle got=%0d exp=0", obs[3:0]); else passed++;
    tick(); tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,2'b10,1'b0,1'b0,4'd10};
    total++; if (obs !== e) $display("FAIL beq_not_taken got=%b exp=%b", obs, e); else passed++;
    tick();
  endtask
  task automatic test_jal();
    bus.op = 7'b1101111;
    tick(); tick();
    e = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,2'b11,1'b0,1'b0,4'd9};
    total++; if (obs !== e) $display("FAIL jal_state got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b11,1'b1,1'b0,4'd8};
    total++; if (obs !== e) $display("FAIL jal_aluwb got=%b exp=%b", obs, e); else passed++;
    tick();
    total++; if (obs[3:0] !== 4'd0) $display("FAIL jal_end got=%0d exp=0", obs[3:0]); else passed++;
  endtask
  task automatic test_illegal();
    bus.op = 7'b1111111;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0,1'b1,4'd1};
    total++; if (obs !== e) $display("FAIL illegal_decode got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL illegal_next_fetch got=%b exp=%b", obs, e); else passed++;
  endtask
  task automatic test_jalr();
    bus.op = 7'b1100111;
    tick();
`ifdef MC_CONTROL_JALR_EN
    tick();
    e = {1'b1,1'b0,1'b0,1'b0,2'b10,2'b10,2'b01,3'b000,2'b00,1'b0,1'b0,4'd11};
    total++; if (obs !== e) $display("FAIL jalr_state got=%b exp=%b", obs, e); else passed++;
    tick();
    e = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,3'b000,2'b00,1'b1,1'b0,4'd12};
    total++; if (obs !== e) $display("FAIL jalr_link got=%b exp=%b", obs, e); else passed++;
`else
    e = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0,1'b1,4'd1};
    total++; if (obs !== e) $display("FAIL jalr_illegal got=%b exp=%b", obs, e); else passed++;
`endif
    tick();
    total++; if (obs[3:0] !== 4'd0) $display("FAIL jalr_end got=%0d exp=0", obs[3:0]); else passed++;
  endtask
  task automatic test_reset_mid_sw();
    bus.op = 7'b0100011;
    tick(); tick(); tick();
    e = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,3'b000,2'b01,1'b0,1'b0,4'd5};
    total++; if (obs !== e) $display("FAIL sw_memwrite got=%b exp=%b", obs, e); else passed++;
    #1 rst_n = 1'b0; #1;
    e = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b01,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL sw_async_reset got=%b exp=%b", obs, e); else passed++;
    tick();
    total++; if (obs !== e) $display("FAIL sw_reset_held got=%b exp=%b", obs, e); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    e = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,3'b000,2'b01,1'b0,1'b0,4'd0};
    total++; if (obs !== e) $display("FAIL sw_release_fetch got=%b exp=%b", obs, e); else passed++;
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype_sub();
    test_itype();
    test_beq();
    test_jal();
    test_illegal();
    test_jalr();
    test_reset_mid_sw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
